// File: rtl/acc_pkg.sv
// acc_pkg: state encoding, drain-length calculation and parameter defaults
// shared by the accumulator loop sequencer and its phase timer.
package acc_pkg;

    localparam int DEF_RING_DEPTH  = 10;
    localparam int DEF_PE_DEPTH    = 3;
    localparam int DEF_STAGE_DELAY = 4;
    localparam int DEF_ITER_W      = 10;
    localparam int DEF_WDOG_CYCLES = 65535;

    typedef logic [2:0] state_t;

    localparam state_t IDLE      = 3'd0;
    localparam state_t LOAD      = 3'd1;
    localparam state_t INTT      = 3'd2;
    localparam state_t DRAIN_DEC = 3'd3;
    localparam state_t NTT       = 3'd4;
    localparam state_t DRAIN_ADD = 3'd5;
    localparam state_t OUTPUT    = 3'd6;

    // Drain length: one pass of the ring through 2*PE lanes plus the pipeline depth.
    function automatic int calc_d(int ring_depth, int pe_depth, int stage_delay);
        return ((1 << ring_depth) >> (pe_depth + 1)) + stage_delay;
    endfunction

    function automatic int timer_width(int a, int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/acc_phase_timer.sv
// acc_phase_timer: loadable down-counter with zero flag; counts the remaining
// cycles of a fixed-length phase and holds at zero.
module acc_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic [W-1:0] count,
    output logic         zero
);

    assign zero = count == '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= value;
        else if (!zero)
            count <= count - W'(1);
    end

endmodule

// File: rtl/acc_loop_sequencer.sv
// acc_loop_sequencer: sequences LOAD, INTT, drains, NTT and OUTPUT of the accumulator loop.
// Define ACC_WATCHDOG_EN to bound the transform waits with a watchdog driving error.
module acc_loop_sequencer
    import acc_pkg::*;
#(
    parameter int RING_DEPTH  = DEF_RING_DEPTH,
    parameter int PE_DEPTH    = DEF_PE_DEPTH,
    parameter int STAGE_DELAY = DEF_STAGE_DELAY,
    parameter int ITER_W      = DEF_ITER_W,
    parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ITER_W-1:0]     num_iter,
    input  logic                  done_intt,
    input  logic                  done_ntt,
    output logic                  busy,
    output logic                  done,
    output logic [ITER_W-1:0]     iter_idx,
    output logic [RING_DEPTH-1:0] in_rd_addr,
    output logic                  load_intt,
    output logic                  start_intt,
    output logic                  load_ntt,
    output logic                  start_ntt,
    output logic                  sel_feedback,
    output logic                  out_we,
    output logic [RING_DEPTH-1:0] out_addr,
    output logic                  error
);

    localparam int RING_SIZE = 1 << RING_DEPTH;
    localparam int D         = calc_d(RING_DEPTH, PE_DEPTH, STAGE_DELAY);
    localparam int TW        = timer_width(RING_SIZE + 2, D);

    state_t            state, nxt;
    logic [1:0]        step;
    logic [ITER_W-1:0] num_iter_l, iter_nxt;
    logic              t_load, t_zero, wd_hit, accept;
    logic [TW-1:0]     t_val, t_cnt;

    acc_phase_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (t_load),
        .value (t_val),
        .count (t_cnt),
        .zero  (t_zero)
    );

    assign accept   = state == IDLE && start;
    assign iter_nxt = iter_idx + ITER_W'(1);

    always_comb begin
        nxt    = state;
        t_load = 1'b0;
        t_val  = TW'(RING_SIZE - 1);
        case (state)
            IDLE: begin
                nxt    = start ? LOAD : IDLE;
                t_load = start;
                t_val  = TW'(RING_SIZE + 1);
            end
            LOAD: begin
                nxt    = !t_zero ? LOAD : (num_iter_l == '0) ? OUTPUT : INTT;
                t_load = t_zero && num_iter_l == '0;
            end
            INTT: begin
                nxt    = (step != 2'd0 && done_intt) ? DRAIN_DEC : INTT;
                t_load = nxt == DRAIN_DEC;
                t_val  = TW'(D - 1);
            end
            DRAIN_DEC: nxt = t_zero ? NTT : DRAIN_DEC;
            NTT: begin
                nxt    = (step != 2'd0 && done_ntt) ? DRAIN_ADD : NTT;
                t_load = nxt == DRAIN_ADD;
                t_val  = TW'(D - 1);
            end
            DRAIN_ADD: begin
                nxt    = !t_zero ? DRAIN_ADD : (iter_nxt == num_iter_l) ? OUTPUT : INTT;
                t_load = t_zero && iter_nxt == num_iter_l;
            end
            OUTPUT:  nxt = t_zero ? IDLE : OUTPUT;
            default: nxt = IDLE;
        endcase
        if (wd_hit && nxt == state)
            nxt = IDLE;
    end

    // step: 0 on the first cycle of a state, 1 on the second, then saturates at 2
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            step       <= 2'd0;
            iter_idx   <= '0;
            num_iter_l <= '0;
            done       <= 1'b0;
        end else begin
            state      <= nxt;
            step       <= (nxt != state) ? 2'd0 : (step == 2'd2) ? step : step + 2'd1;
            iter_idx   <= accept ? '0 : (state == DRAIN_ADD && t_zero) ? iter_nxt : iter_idx;
            num_iter_l <= accept ? num_iter : num_iter_l;
            done       <= state == OUTPUT && t_zero;
        end
    end

`ifdef ACC_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wd_cnt;

    assign wd_hit = (state == INTT || state == NTT) && wd_cnt == WW'(WDOG_CYCLES - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
            error  <= 1'b0;
        end else begin
            wd_cnt <= ((state == INTT || state == NTT) && nxt == state) ? wd_cnt + WW'(1) : '0;
            error  <= (wd_hit && nxt == IDLE) ? 1'b1 : accept ? 1'b0 : error;
        end
    end
`else
    assign wd_hit = 1'b0;
    assign error  = 1'b0;
`endif

    assign busy         = state != IDLE;
    assign in_rd_addr   = (state == LOAD) ? RING_DEPTH'(TW'(RING_SIZE + 1) - t_cnt) : '0;
    assign load_intt    = state == LOAD && t_cnt == TW'(RING_SIZE);
    assign start_intt   = state == INTT && step == 2'd1;
    assign load_ntt     = state == DRAIN_DEC && t_cnt == TW'(D - 1);
    assign start_ntt    = state == NTT && step == 2'd1;
    assign sel_feedback = (state == INTT || state == DRAIN_DEC || state == NTT || state == DRAIN_ADD)
                          && iter_idx != '0;
    assign out_we       = state == OUTPUT;
    assign out_addr     = (state == OUTPUT) ? RING_DEPTH'(TW'(RING_SIZE - 1) - t_cnt) : '0;

endmodule

// File: tb/tb_acc_loop_sequencer.sv
// tb_acc_loop_sequencer: per-cycle trace tables built from the phase rules, random runs,
// mid-run reset and (with ACC_WATCHDOG_EN) watchdog sequences.
module tb_acc_loop_sequencer;

    localparam int RD = 4, PD = 1, SD = 3, IW = 10, WD = 50;
    localparam int RS = 1 << RD;
    localparam int DD = ((1 << RD) >> (PD + 1)) + SD;

    typedef struct packed {
        logic          start;
        logic [IW-1:0] n;
        logic          di, dn;
    } in_t;

    typedef struct packed {
        logic          busy, done;
        logic [IW-1:0] iter;
        logic [RD-1:0] rd;
        logic          ld_intt, st_intt, ld_ntt, st_ntt, fb, we;
        logic [RD-1:0] oa;
        logic          err;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic          clk = 0, reset = 1, start = 0, done_intt = 0, done_ntt = 0;
    logic [IW-1:0] num_iter = '0;
    logic          busy, done, load_intt, start_intt, load_ntt, start_ntt, sel_feedback, out_we, error;
    logic [IW-1:0] iter_idx;
    logic [RD-1:0] in_rd_addr, out_addr;

    int            checks = 0, errors = 0;
    logic [IW-1:0] last_iter = '0;
    vec_t          tbl[$];

    acc_loop_sequencer #(
        .RING_DEPTH(RD), .PE_DEPTH(PD), .STAGE_DELAY(SD), .ITER_W(IW), .WDOG_CYCLES(WD)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_iter(num_iter),
        .done_intt(done_intt), .done_ntt(done_ntt), .busy(busy), .done(done),
        .iter_idx(iter_idx), .in_rd_addr(in_rd_addr), .load_intt(load_intt),
        .start_intt(start_intt), .load_ntt(load_ntt), .start_ntt(start_ntt),
        .sel_feedback(sel_feedback), .out_we(out_we), .out_addr(out_addr), .error(error)
    );

    always #5 clk = ~clk;

    function automatic out_t sample();
        return {busy, done, iter_idx, in_rd_addr, load_intt, start_intt, load_ntt,
                start_ntt, sel_feedback, out_we, out_addr, error};
    endfunction

    task automatic check(input string nm, input out_t want);
        out_t got = sample();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    task automatic check_bit(input string nm, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b, want %b", nm, got, want);
        end
    endtask

    function automatic logic rnd(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    function automatic in_t busy_in(input int p);
        in_t i;
        i.start = rnd(p);
        i.n     = IW'($urandom);
        i.di    = rnd(p);
        i.dn    = rnd(p);
        return i;
    endfunction

    function automatic out_t loop_o(input int it);
        out_t o = '0;
        o.busy = 1'b1;
        o.iter = IW'(it);
        o.fb   = it != 0;
        return o;
    endfunction

    task automatic put(input in_t i, input out_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        tbl.push_back(v);
    endtask

    // Expected trace of one run: start cycle, LOAD, n loop bodies, OUTPUT, done cycle.
    // p is the percentage chance of spurious start/done pulses where they must be ignored.
    task automatic build_run(input int n, input int p);
        in_t  i;
        out_t o;
        int   a;
        i = busy_in(p);
        i.start = 1'b1;
        i.n = IW'(n);
        o = '0;
        o.iter = last_iter;
        put(i, o);
        for (int k = 0; k < RS + 2; k++) begin
            o = '0;
            o.busy = 1'b1;
            o.rd = RD'(k);
            o.ld_intt = k == 1;
            put(busy_in(p), o);
        end
        for (int it = 0; it < n; it++) begin
            a = $urandom_range(1, 5);
            for (int j = 0; j <= a + 1; j++) begin
                i = busy_in(p);
                i.di = (j == a + 1) || (j == 0 && rnd(p));
                o = loop_o(it);
                o.st_intt = j == 1;
                put(i, o);
            end
            for (int k = 0; k < DD; k++) begin
                o = loop_o(it);
                o.ld_ntt = k == 0;
                put(busy_in(p), o);
            end
            a = $urandom_range(1, 5);
            for (int j = 0; j <= a + 1; j++) begin
                i = busy_in(p);
                i.dn = (j == a + 1) || (j == 0 && rnd(p));
                o = loop_o(it);
                o.st_ntt = j == 1;
                put(i, o);
            end
            for (int k = 0; k < DD; k++)
                put(busy_in(p), loop_o(it));
        end
        for (int k = 0; k < RS; k++) begin
            o = '0;
            o.busy = 1'b1;
            o.iter = IW'(n);
            o.we = 1'b1;
            o.oa = RD'(k);
            put(busy_in(p), o);
        end
        i = busy_in(p);
        i.start = 1'b0;
        o = '0;
        o.done = 1'b1;
        o.iter = IW'(n);
        put(i, o);
        last_iter = IW'(n);
    endtask

    task automatic run_tbl(input string nm, input int lim);
        for (int k = 0; k < tbl.size() && k < lim; k++) begin
            @(posedge clk);
            #1;
            start     = tbl[k].i.start;
            num_iter  = tbl[k].i.n;
            done_intt = tbl[k].i.di;
            done_ntt  = tbl[k].i.dn;
            @(negedge clk);
            check($sformatf("%s[%0d]", nm, k), tbl[k].o);
        end
        tbl.delete();
    endtask

    task automatic idle_inputs();
        start = 0;
        num_iter = '0;
        done_intt = 0;
        done_ntt = 0;
    endtask

    initial begin
        int lim, n;
        repeat (2) @(posedge clk);
        #1 check("reset_state", '0);
        @(negedge clk) reset = 0;
        check("after_release", '0);

        build_run(2, 0);
        run_tbl("iter2", 1 << 30);
        build_run(0, 0);
        run_tbl("iter0", 1 << 30);
        build_run(2, 35);
        run_tbl("iter2_spurious", 1 << 30);
        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(0, 3);
            build_run(n, 25);
            run_tbl($sformatf("rand%0d_n%0d", r, n), 1 << 30);
        end

        build_run(1, 20);
        lim = 0;
        for (int k = 0; k < tbl.size(); k++)
            if (tbl[k].o.ld_ntt && lim == 0) lim = k + 3;
        run_tbl("pre_reset", lim);
        #2 reset = 1;
        #1 check("reset_in_drain_dec", '0);
        idle_inputs();
        @(posedge clk);
        @(negedge clk) reset = 0;
        check("reset_released", '0);
        last_iter = '0;
        build_run(1, 0);
        run_tbl("after_reset", 1 << 30);

`ifdef ACC_WATCHDOG_EN
        @(posedge clk);
        #1 start = 1;
        num_iter = IW'(1);
        @(negedge clk) check_bit("wd_start_idle", busy, 1'b0);
        @(posedge clk);
        #1 start = 0;
        for (int c = 0; c < RS + 2 + WD; c++) begin
            @(negedge clk);
            check_bit($sformatf("wd_busy[%0d]", c), busy, 1'b1);
            check_bit($sformatf("wd_err[%0d]", c), error, 1'b0);
        end
        @(negedge clk);
        check_bit("wd_trip_busy", busy, 1'b0);
        check_bit("wd_trip_err", error, 1'b1);
        @(posedge clk);
        #1 start = 1;
        @(negedge clk) check_bit("wd_err_sticky", error, 1'b1);
        @(posedge clk);
        #1 start = 0;
        @(negedge clk);
        check_bit("wd_err_cleared", error, 1'b0);
        check_bit("wd_restart_busy", busy, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
